toggle_event_gen: RTL and testbench
===================================

Name: toggle_event_gen

Overview:
- Upstream feeder for the per-module toggle-coverage reporters.
- Samples a watched signal vector every cycle and detects per-bit rising and falling transitions.
- Emits a registered one-cycle pulse vector of width 2*SIG_W, which drives the reporter's valid input.
- Keeps a sticky covered mask plus a covered-point count for in-simulation and FPGA coverage readout.

Parameters:
- SIG_W, 22, width of watched signal; output point count OUT_W = 2*SIG_W (localparam).
- CNT_W, $clog2(2*SIG_W+1), width of covered_cnt (localparam, derived).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  event gating; 0 suppresses event generation, sampling continues.
- clear  in  1  synchronous clear of covered/covered_cnt/all_covered only.
- sig  in  SIG_W  watched signal vector.
- valid  out  OUT_W  event pulses; bit 2i = bit i rose, bit 2i+1 = bit i fell.
- covered  out  OUT_W  sticky mask of points hit since reset/clear.
- covered_cnt  out  CNT_W  popcount of covered.
- all_covered  out  1  high iff covered_cnt == OUT_W.

Behaviour:
- Reset (sync, active-high): prev=0, armed=0, valid=0, covered=0, covered_cnt=0, all_covered=0; reset overrides every other input.
- Sampling: prev <= sig every non-reset edge, independent of enable.
- Arming: armed <= 1 on the first non-reset edge, so the first post-reset sample never produces events.
- Event terms: rise_i = armed & enable & ~prev_i & sig_i; fall_i = armed & enable & prev_i & ~sig_i.
- Output timing: valid <= events at edge N, using sig at edge N versus prev captured at edge N-1. The pulse lasts exactly one cycle after edge N, giving 1-cycle latency from sampling.
- A bit held constant produces no pulse.
- A bit changing every cycle produces alternating rise/fall pulses on consecutive cycles.
- enable=0: valid is 0 next cycle. Toggles during the disabled window are never reported late, because prev keeps tracking.
- covered <= (clear ? 0 : covered) | events. An event in the same cycle as clear is retained.
- covered_cnt and all_covered are registered from next-covered, so they update at the same edge as covered. No extra latency.
- covered_cnt saturates naturally at OUT_W. No wrap is possible.
- Reset mid-operation: a pending valid pulse is dropped, and the first post-reset sample is re-armed.

Optional Feature:
- Macro: TOGGLE_FIRST_HIT_ONLY_EN.
- Defined: valid bit k pulses only when covered[k] is 0 before the edge (first hit since reset/clear). Subsequent hits update nothing, which reduces reporter traffic.
- Undefined: every transition pulses.
- covered, covered_cnt and all_covered behave identically in both builds.

Decomposition:
- Package toggle_cov_pkg holds:
  - function rise_idx(i)=2*i and fall_idx(i)=2*i+1;
  - CNT_W helper function;
  - point-kind encoding constants (POINT_RISE=0, POINT_FALL=1).
- One sub-module, toggle_popcount: parameterised combinational popcount of an OUT_W vector, instantiated for covered_cnt.

Test Plan:
- Reset release with sig=0x3FFFFF, then hold: valid stays 0x0 for every cycle, covered=0, covered_cnt=0.
- From sig=0, set bit0 for one cycle then clear it:
  - valid=0x1 for one cycle, then valid=0x2 for one cycle, then 0;
  - covered=0x3, covered_cnt=2.
- enable=0 while bit5 goes 0→1, then enable=1 with sig held: valid never shows bit 10; covered unchanged.
- Raise then lower all 22 bits: covered=0xFFFFFFFFFFF, covered_cnt=44, all_covered=1; clear → all three return to 0 next cycle.
- clear asserted in the same cycle bit3 rises: covered=0x40, covered_cnt=1.
- With TOGGLE_FIRST_HIT_ONLY_EN, a second rise of bit0 gives valid=0; without the macro it gives valid=0x1.
- reset asserted the cycle a rise is sampled: valid=0 next cycle and the following post-reset sample produces no event.

Source files
------------

// File: rtl/toggle_cov_pkg.sv
// Shared definitions for the toggle-coverage event generator: point indexing and width helpers.
package toggle_cov_pkg;

  localparam int unsigned POINT_RISE = 0;
  localparam int unsigned POINT_FALL = 1;

  function automatic int unsigned rise_idx(input int unsigned i);
    return 2 * i + POINT_RISE;
  endfunction

  function automatic int unsigned fall_idx(input int unsigned i);
    return 2 * i + POINT_FALL;
  endfunction

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count of a W-bit vector.
module toggle_popcount #(
  parameter int unsigned W  = 44,
  parameter int unsigned CW = 6
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count_c = count_c + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/toggle_event_gen.sv
// Per-bit rise/fall event pulses plus sticky toggle coverage for a watched vector.
// Build option: define TOGGLE_FIRST_HIT_ONLY_EN to pulse valid only on the first hit of each point.
module toggle_event_gen
  import toggle_cov_pkg::*;
#(
  parameter int unsigned SIG_W = 22
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [SIG_W-1:0]                  sig,
  output logic [2*SIG_W-1:0]                valid,
  output logic [2*SIG_W-1:0]                covered,
  output logic [cnt_width(2*SIG_W)-1:0]     covered_cnt,
  output logic                              all_covered
);

  localparam int unsigned OUT_W = 2 * SIG_W;
  localparam int unsigned CNT_W = cnt_width(OUT_W);

  logic [SIG_W-1:0] prev;
  logic             armed;
  logic [OUT_W-1:0] events_c;
  logic [OUT_W-1:0] pulses_c;
  logic [OUT_W-1:0] covered_next_c;
  logic [CNT_W-1:0] cnt_next_c;

  // Interleave rise/fall terms so each watched bit owns two adjacent points.
  always_comb begin
    events_c = '0;
    for (int unsigned i = 0; i < SIG_W; i++) begin
      events_c[rise_idx(i)] = armed & enable & ~prev[i] &  sig[i];
      events_c[fall_idx(i)] = armed & enable &  prev[i] & ~sig[i];
    end
  end

`ifdef TOGGLE_FIRST_HIT_ONLY_EN
  assign pulses_c = events_c & ~covered;
`else
  assign pulses_c = events_c;
`endif

  // A same-cycle event survives a clear.
  assign covered_next_c = (clear ? '0 : covered) | events_c;

  toggle_popcount #(
    .W  (OUT_W),
    .CW (CNT_W)
  ) u_popcount (
    .vec     (covered_next_c),
    .count_c (cnt_next_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      prev        <= '0;
      armed       <= 1'b0;
      valid       <= '0;
      covered     <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else begin
      prev        <= sig;
      armed       <= 1'b1;
      valid       <= pulses_c;
      covered     <= covered_next_c;
      covered_cnt <= cnt_next_c;
      all_covered <= (cnt_next_c == CNT_W'(OUT_W));
    end
  end

endmodule

// File: tb/tb_toggle_event_gen.sv
// Directed self-checking bench for toggle_event_gen (default SIG_W = 22).
module tb_toggle_event_gen;

  localparam int unsigned SIG_W = 22;
  localparam int unsigned OUT_W = 44;
  localparam int unsigned CNT_W = 6;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             clear;
  logic [SIG_W-1:0] sig;
  logic [OUT_W-1:0] valid;
  logic [OUT_W-1:0] covered;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  int n_checks;
  int n_fail;

  toggle_event_gen #(.SIG_W(SIG_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered     (covered),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  always #5 clock = ~clock;

  // Advance one edge; outputs are stable and inputs may be changed afterwards.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [SIG_W-1:0] s);
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    sig    = s;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    sig    = 22'h3FFFFF;
    step();
    n_checks++;
    if (valid !== 44'h0 || covered !== 44'h0 || covered_cnt !== 6'd0 || all_covered !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state valid=%h covered=%h cnt=%0d all=%b want all zero", valid, covered, covered_cnt, all_covered);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (valid !== 44'h0 || covered !== 44'h0 || covered_cnt !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_release_hold cyc=%0d valid=%h covered=%h cnt=%0d want 0/0/0", c, valid, covered, covered_cnt);
      end
    end
  endtask

  task automatic test_single_bit();
    do_reset(22'h0);
    sig = 22'h1;
    step();
    n_checks++;
    if (valid !== 44'h1) begin
      n_fail++;
      $display("FAIL single_rise valid=%h want %h", valid, 44'h1);
    end
    sig = 22'h0;
    step();
    n_checks++;
    if (valid !== 44'h2) begin
      n_fail++;
      $display("FAIL single_fall valid=%h want %h", valid, 44'h2);
    end
    step();
    n_checks++;
    if (valid !== 44'h0) begin
      n_fail++;
      $display("FAIL single_idle valid=%h want 0", valid);
    end
    n_checks++;
    if (covered !== 44'h3 || covered_cnt !== 6'd2 || all_covered !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cov covered=%h cnt=%0d all=%b want 3/2/0", covered, covered_cnt, all_covered);
    end
  endtask

  task automatic test_enable();
    do_reset(22'h0);
    enable = 1'b0;
    sig    = 22'h20;
    step();
    n_checks++;
    if (valid !== 44'h0) begin
      n_fail++;
      $display("FAIL enable_off valid=%h want 0", valid);
    end
    enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (valid !== 44'h0) begin
        n_fail++;
        $display("FAIL enable_no_late cyc=%0d valid=%h want 0", c, valid);
      end
    end
    n_checks++;
    if (covered !== 44'h0 || covered_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL enable_cov covered=%h cnt=%0d want 0/0", covered, covered_cnt);
    end
  endtask

  task automatic test_all_bits();
    do_reset(22'h0);
    sig = 22'h3FFFFF;
    step();
    n_checks++;
    if (valid !== 44'h55555555555) begin
      n_fail++;
      $display("FAIL all_rise valid=%h want %h", valid, 44'h55555555555);
    end
    sig = 22'h0;
    step();
    n_checks++;
    if (valid !== 44'hAAAAAAAAAAA) begin
      n_fail++;
      $display("FAIL all_fall valid=%h want %h", valid, 44'hAAAAAAAAAAA);
    end
    n_checks++;
    if (covered !== 44'hFFFFFFFFFFF || covered_cnt !== 6'd44 || all_covered !== 1'b1) begin
      n_fail++;
      $display("FAIL all_cov covered=%h cnt=%0d all=%b want fff..f/44/1", covered, covered_cnt, all_covered);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (covered !== 44'h0 || covered_cnt !== 6'd0 || all_covered !== 1'b0) begin
      n_fail++;
      $display("FAIL all_clear covered=%h cnt=%0d all=%b want 0/0/0", covered, covered_cnt, all_covered);
    end
  endtask

  task automatic test_clear_same_cycle();
    do_reset(22'h0);
    sig = 22'h1;
    step();
    clear = 1'b1;
    sig   = 22'h9;
    step();
    clear = 1'b0;
    n_checks++;
    if (covered !== 44'h40 || covered_cnt !== 6'd1 || valid !== 44'h40) begin
      n_fail++;
      $display("FAIL clear_same covered=%h cnt=%0d valid=%h want 40/1/40", covered, covered_cnt, valid);
    end
  endtask

  task automatic test_first_hit();
    logic [OUT_W-1:0] exp_v;
`ifdef TOGGLE_FIRST_HIT_ONLY_EN
    exp_v = 44'h0;
`else
    exp_v = 44'h1;
`endif
    do_reset(22'h0);
    sig = 22'h1;
    step();
    sig = 22'h0;
    step();
    sig = 22'h1;
    step();
    n_checks++;
    if (valid !== exp_v) begin
      n_fail++;
      $display("FAIL second_rise valid=%h want %h", valid, exp_v);
    end
    n_checks++;
    if (covered !== 44'h3 || covered_cnt !== 6'd2) begin
      n_fail++;
      $display("FAIL second_rise_cov covered=%h cnt=%0d want 3/2", covered, covered_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] exp_v;
    do_reset(22'h0);
    for (int c = 0; c < 4; c++) begin
      sig = (c % 2 == 0) ? 22'h400 : 22'h0;
`ifdef TOGGLE_FIRST_HIT_ONLY_EN
      exp_v = (c < 2) ? ((c % 2 == 0) ? 44'h100000 : 44'h200000) : 44'h0;
`else
      exp_v = (c % 2 == 0) ? 44'h100000 : 44'h200000;
`endif
      step();
      n_checks++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d valid=%h want %h", c, valid, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(22'h0);
    sig   = 22'h1;
    reset = 1'b1;
    step();
    n_checks++;
    if (valid !== 44'h0 || covered !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_mid_drop valid=%h covered=%h want 0/0", valid, covered);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (valid !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_mid_rearm valid=%h want 0", valid);
    end
    sig = 22'h0;
    step();
    n_checks++;
    if (valid !== 44'h2 || covered_cnt !== 6'd1) begin
      n_fail++;
      $display("FAIL reset_mid_after valid=%h cnt=%0d want 2/1", valid, covered_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clock    = 1'b0;
    reset    = 1'b1;
    enable   = 1'b1;
    clear    = 1'b0;
    sig      = '0;
    test_reset();
    test_single_bit();
    test_enable();
    test_all_bits();
    test_clear_same_cycle();
    test_first_hit();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
